// File: rtl/icache_pkg.sv
// Shared types and default geometry for the set-associative instruction cache.
package icache_pkg;

    localparam int DEF_LINE_IX_BITWIDTH                = 1;
    localparam int DEF_WAYS_BITWIDTH                   = 1;
    localparam int DEF_ADDRESS_BITWIDTH                = 32;
    localparam int DEF_INSTRUCTION_BITWIDTH            = 32;
    localparam int DEF_INSTRUCTION_IX_IN_LINE_BITWIDTH = 3;
    localparam int DEF_RAM_DEPTH_BITWIDTH              = 4;
    localparam int DEF_RAM_BURST_DATA_BITWIDTH         = 64;
    localparam int DEF_RAM_BURST_DATA_COUNT            = 4;

    // One burst must fill exactly one cache line.
    function automatic bit line_matches_burst(input int instr_w, input int ix_bits,
                                              input int beat_w, input int beat_cnt);
        return ((instr_w << ix_bits) / 8) == ((beat_w * beat_cnt) / 8);
    endfunction

    localparam int OFFSET_BITWIDTH = $clog2(DEF_INSTRUCTION_BITWIDTH / 8);
    localparam int INDEX_BITWIDTH  = DEF_LINE_IX_BITWIDTH;
    localparam int TAG_BITWIDTH    = DEF_ADDRESS_BITWIDTH - OFFSET_BITWIDTH
                                     - DEF_INSTRUCTION_IX_IN_LINE_BITWIDTH - INDEX_BITWIDTH;
    localparam int WAYS            = 1 << DEF_WAYS_BITWIDTH;
    localparam int LINE_BITWIDTH   = DEF_INSTRUCTION_BITWIDTH << DEF_INSTRUCTION_IX_IN_LINE_BITWIDTH;
    localparam int BEATS_PER_LINE  = LINE_BITWIDTH / DEF_RAM_BURST_DATA_BITWIDTH;
    localparam bit LINE_MATCHES_BURST = line_matches_burst(DEF_INSTRUCTION_BITWIDTH,
                                                           DEF_INSTRUCTION_IX_IN_LINE_BITWIDTH,
                                                           DEF_RAM_BURST_DATA_BITWIDTH,
                                                           DEF_RAM_BURST_DATA_COUNT);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        REQ,
        FILL,
        FLUSH
    } state_t;

endpackage

// File: rtl/icache_way_store.sv
// One cache way: per-set tag, valid bit and line data, with combinational
// lookup read and beat-granular fill writes.
module icache_way_store
    import icache_pkg::*;
#(
    parameter int SET_W     = DEF_LINE_IX_BITWIDTH,
    parameter int TAG_W     = TAG_BITWIDTH,
    parameter int LINE_W    = LINE_BITWIDTH,
    parameter int BEAT_W    = DEF_RAM_BURST_DATA_BITWIDTH,
    parameter int BEAT_IX_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SET_W-1:0]     set_ix,
    input  logic                 flush_all,
    input  logic                 invalidate,
    input  logic                 beat_we,
    input  logic [BEAT_IX_W-1:0] beat_ix,
    input  logic [BEAT_W-1:0]    beat_data,
    input  logic                 tag_we,
    input  logic [TAG_W-1:0]     wr_tag,
    output logic [TAG_W-1:0]     rd_tag,
    output logic                 rd_valid,
    output logic [LINE_W-1:0]    rd_line
);

    localparam int NUM_SETS = 1 << SET_W;

    logic [NUM_SETS-1:0] valid_q;
    logic [TAG_W-1:0]    tag_q  [NUM_SETS];
    logic [LINE_W-1:0]   data_q [NUM_SETS];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (flush_all) begin
            valid_q <= '0;
        end else if (tag_we) begin
            valid_q[set_ix] <= 1'b1;
        end else if (invalidate) begin
            valid_q[set_ix] <= 1'b0;
        end
    end

    // NOTE: tag and data arrays are not reset; the valid bits alone decide
    // whether their contents mean anything, which keeps them RAM-mappable.
    always_ff @(posedge clk) begin
        if (beat_we) begin
            data_q[set_ix][32'(beat_ix) * BEAT_W +: BEAT_W] <= beat_data;
        end
        if (tag_we) begin
            tag_q[set_ix] <= wr_tag;
        end
    end

    assign rd_tag   = tag_q[set_ix];
    assign rd_valid = valid_q[set_ix];
    assign rd_line  = data_q[set_ix];

endmodule

// File: rtl/icache_assoc.sv
// Set-associative read-only instruction cache in front of BurstRAM, with
// round-robin replacement and critical-word early data_ready.
// Optional hit/miss/flush counters are built when ICACHE_STATS_EN is defined.
module icache_assoc
    import icache_pkg::*;
#(
    parameter int LINE_IX_BITWIDTH                = DEF_LINE_IX_BITWIDTH,
    parameter int WAYS_BITWIDTH                   = DEF_WAYS_BITWIDTH,
    parameter int ADDRESS_BITWIDTH                = DEF_ADDRESS_BITWIDTH,
    parameter int INSTRUCTION_BITWIDTH            = DEF_INSTRUCTION_BITWIDTH,
    parameter int INSTRUCTION_IX_IN_LINE_BITWIDTH = DEF_INSTRUCTION_IX_IN_LINE_BITWIDTH,
    parameter int RAM_DEPTH_BITWIDTH              = DEF_RAM_DEPTH_BITWIDTH,
    parameter int RAM_BURST_DATA_BITWIDTH         = DEF_RAM_BURST_DATA_BITWIDTH,
    parameter int RAM_BURST_DATA_COUNT            = DEF_RAM_BURST_DATA_COUNT
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 enable,
    input  logic [ADDRESS_BITWIDTH-1:0]          address,
    input  logic                                 flush,
    output logic [INSTRUCTION_BITWIDTH-1:0]      instruction,
    output logic                                 data_ready,
    output logic                                 busy,
    output logic                                 br_cmd,
    output logic                                 br_cmd_en,
    output logic [RAM_DEPTH_BITWIDTH-1:0]        br_addr,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_wr_data,
    output logic [RAM_BURST_DATA_BITWIDTH/8-1:0] br_data_mask,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_rd_data,
    input  logic                                 br_rd_data_valid,
    input  logic                                 br_busy
);

    localparam int OFF_W          = $clog2(INSTRUCTION_BITWIDTH / 8);
    localparam int IX_W           = INSTRUCTION_IX_IN_LINE_BITWIDTH;
    localparam int SET_W          = LINE_IX_BITWIDTH;
    localparam int WADDR_W        = ADDRESS_BITWIDTH - OFF_W;
    localparam int TAG_W          = WADDR_W - IX_W - SET_W;
    localparam int NUM_WAYS       = 1 << WAYS_BITWIDTH;
    localparam int NUM_SETS       = 1 << SET_W;
    localparam int LINE_W         = INSTRUCTION_BITWIDTH << IX_W;
    localparam int WORDS_PER_BEAT = RAM_BURST_DATA_BITWIDTH / INSTRUCTION_BITWIDTH;
    localparam int BEAT_IX_W      = (RAM_BURST_DATA_COUNT > 1) ? $clog2(RAM_BURST_DATA_COUNT) : 1;

    if (!line_matches_burst(INSTRUCTION_BITWIDTH, IX_W, RAM_BURST_DATA_BITWIDTH,
                            RAM_BURST_DATA_COUNT)) begin : g_geometry_bad
        $error("icache_assoc: line byte count differs from burst byte count");
    end

    state_t state, state_next;

    logic [WADDR_W-1:0]         waddr_q;
    logic [WAYS_BITWIDTH-1:0]   victim_q, victim, hit_way;
    logic [BEAT_IX_W-1:0]       beat_cnt_q, crit_beat;
    logic                       flush_pending_q;
    logic [WAYS_BITWIDTH-1:0]   rr_q [NUM_SETS];

    logic [TAG_W-1:0]           way_tag  [NUM_WAYS];
    logic [LINE_W-1:0]          way_line [NUM_WAYS];
    logic [NUM_WAYS-1:0]        way_valid, hit_vec;
    logic                       hit;
    logic [INSTRUCTION_BITWIDTH-1:0] hit_word, beat_word;

    logic [SET_W-1:0]           set_q;
    logic [TAG_W-1:0]           tag_q;
    logic [IX_W-1:0]            word_ix_q;
    logic [WADDR_W-IX_W-1:0]    line_addr;

    logic take_flush, accept, enter_fill, beat_in, last_beat;

    assign set_q     = waddr_q[IX_W +: SET_W];
    assign tag_q     = waddr_q[WADDR_W-1 -: TAG_W];
    assign word_ix_q = waddr_q[IX_W-1:0];
    assign line_addr = waddr_q[WADDR_W-1:IX_W];

    // Out-of-range line addresses alias in the RAM; the full tag keeps them apart.
    assign br_addr      = RAM_DEPTH_BITWIDTH'(ADDRESS_BITWIDTH'(line_addr)
                                              * ADDRESS_BITWIDTH'(RAM_BURST_DATA_COUNT));
    assign br_cmd       = 1'b0;
    assign br_wr_data   = '0;
    assign br_data_mask = '0;

    assign take_flush = (state == IDLE) && (flush || flush_pending_q);
    assign accept     = (state == IDLE) && !take_flush && enable;
    assign enter_fill = (state == REQ) && !br_busy;
    assign beat_in    = (state == FILL) && br_rd_data_valid;
    assign last_beat  = (beat_cnt_q == BEAT_IX_W'(RAM_BURST_DATA_COUNT - 1));
    assign crit_beat  = BEAT_IX_W'(32'(word_ix_q) / WORDS_PER_BEAT);
    assign beat_word  = br_rd_data[(32'(word_ix_q) % WORDS_PER_BEAT) * INSTRUCTION_BITWIDTH
                                   +: INSTRUCTION_BITWIDTH];
    assign hit        = |hit_vec;

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        logic is_victim;
        assign is_victim = (victim_q == WAYS_BITWIDTH'(w));

        icache_way_store #(
            .SET_W     (SET_W),
            .TAG_W     (TAG_W),
            .LINE_W    (LINE_W),
            .BEAT_W    (RAM_BURST_DATA_BITWIDTH),
            .BEAT_IX_W (BEAT_IX_W)
        ) u_store (
            .clk        (clk),
            .rst        (rst),
            .set_ix     (set_q),
            .flush_all  (state == FLUSH),
            .invalidate (enter_fill && is_victim),
            .beat_we    (beat_in && is_victim),
            .beat_ix    (beat_cnt_q),
            .beat_data  (br_rd_data),
            .tag_we     (beat_in && last_beat && is_victim),
            .wr_tag     (tag_q),
            .rd_tag     (way_tag[w]),
            .rd_valid   (way_valid[w]),
            .rd_line    (way_line[w])
        );
    end

    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        hit_vec = '0;
        hit_way = '0;
        victim  = rr_q[set_q];
        for (int w = 0; w < NUM_WAYS; w++) begin
            hit_vec[w] = way_valid[w] && (way_tag[w] == tag_q);
        end
        // Descending scan so the lowest matching / lowest invalid way wins.
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w]) hit_way = WAYS_BITWIDTH'(w);
            if (!way_valid[w]) victim = WAYS_BITWIDTH'(w);
        end
        hit_word = way_line[hit_way][32'(word_ix_q) * INSTRUCTION_BITWIDTH +: INSTRUCTION_BITWIDTH];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        br_cmd_en  = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (take_flush)  state_next = FLUSH;
                else if (enable) state_next = LOOKUP;
            end
            LOOKUP: state_next = hit ? IDLE : REQ;
            REQ: begin
                if (!br_busy) begin
                    br_cmd_en  = 1'b1;
                    state_next = FILL;
                end
            end
            FILL: begin
                if (beat_in && last_beat) state_next = IDLE;
            end
            FLUSH:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            waddr_q         <= '0;
            victim_q        <= '0;
            beat_cnt_q      <= '0;
            instruction     <= '0;
            data_ready      <= 1'b0;
            flush_pending_q <= 1'b0;
            for (int s = 0; s < NUM_SETS; s++) rr_q[s] <= '0;
        end else begin
            if (take_flush)                    flush_pending_q <= 1'b0;
            else if (flush && state != IDLE)   flush_pending_q <= 1'b1;

            if (accept) begin
                waddr_q    <= address[ADDRESS_BITWIDTH-1:OFF_W];
                data_ready <= 1'b0;
            end

            if (state == LOOKUP) begin
                if (hit) begin
                    instruction <= hit_word;
                    data_ready  <= 1'b1;
                end else begin
                    victim_q <= victim;
                end
            end

            if (enter_fill) beat_cnt_q <= '0;

            if (beat_in) begin
                beat_cnt_q <= beat_cnt_q + BEAT_IX_W'(1);
                // The requester is released as soon as its word lands.
                if (beat_cnt_q == crit_beat) begin
                    instruction <= beat_word;
                    data_ready  <= 1'b1;
                end
                if (last_beat) rr_q[set_q] <= rr_q[set_q] + WAYS_BITWIDTH'(1);
            end
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] stat_cache_hits;
    logic [31:0] stat_cache_misses;
    logic [31:0] stat_flushes;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_cache_hits   <= '0;
            stat_cache_misses <= '0;
            stat_flushes      <= '0;
        end else begin
            if (state == LOOKUP && hit)  stat_cache_hits   <= stat_cache_hits + 32'd1;
            if (state == LOOKUP && !hit) stat_cache_misses <= stat_cache_misses + 32'd1;
            if (take_flush)              stat_flushes      <= stat_flushes + 32'd1;
        end
    end
`else
`endif

endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc with a small BurstRAM responder model.
module tb_icache_assoc;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] address = '0;
    logic        flush = 1'b0;
    logic [31:0] instruction;
    logic        data_ready, busy;
    logic        br_cmd, br_cmd_en;
    logic [3:0]  br_addr;
    logic [63:0] br_wr_data;
    logic [7:0]  br_data_mask;
    logic [63:0] br_rd_data = '0;
    logic        br_rd_data_valid = 1'b0;
    logic        br_busy = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [63:0] ram [16];
    logic [3:0]  ram_ptr = '0;
    int          ram_lat = 0;
    int          ram_left = 0;

    icache_assoc dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .address          (address),
        .flush            (flush),
        .instruction      (instruction),
        .data_ready       (data_ready),
        .busy             (busy),
        .br_cmd           (br_cmd),
        .br_cmd_en        (br_cmd_en),
        .br_addr          (br_addr),
        .br_wr_data       (br_wr_data),
        .br_data_mask     (br_data_mask),
        .br_rd_data       (br_rd_data),
        .br_rd_data_valid (br_rd_data_valid),
        .br_busy          (br_busy)
    );

    always #5 clk = ~clk;

    // BurstRAM: 2-cycle latency, then 4 consecutive beats; busy until the last beat.
    always @(posedge clk) begin
        br_rd_data_valid <= 1'b0;
        if (br_cmd_en && !br_busy) begin
            ram_ptr  <= br_addr;
            ram_lat  <= 2;
            ram_left <= 4;
            br_busy  <= 1'b1;
        end else if (ram_left > 0) begin
            if (ram_lat > 0) begin
                ram_lat <= ram_lat - 1;
            end else begin
                br_rd_data_valid <= 1'b1;
                br_rd_data       <= ram[ram_ptr];
                ram_ptr          <= ram_ptr + 4'd1;
                ram_left         <= ram_left - 1;
                if (ram_left == 1) br_busy <= 1'b0;
            end
        end
    end

    task automatic fetch(input logic [31:0] a, output logic [31:0] ins, output bit saw_cmd,
                         output logic [3:0] cmd_addr, output bit early);
        bit done;
        done = 0; saw_cmd = 0; early = 0; cmd_addr = '0;
        @(negedge clk);
        enable = 1'b1; address = a;
        @(posedge clk);
        #1 enable = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (br_cmd_en) begin saw_cmd = 1; cmd_addr = br_addr; end
            if (data_ready && busy) early = 1;
            if (!busy) begin done = 1; break; end
        end
        ins = instruction;
        total++;
        if (!done) begin bad++; $display("FAIL fetch_timeout addr=%h busy got=%b exp=0", a, busy); end
    endtask

    task automatic test_reset();
        logic [31:0] ins; bit cmd, early; logic [3:0] ca;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++; if (instruction !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h exp=0", instruction); end
        total++; if (data_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", data_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (br_cmd_en !== 1'b0) begin bad++; $display("FAIL rst_cmd_en got=%b exp=0", br_cmd_en); end
        total++; if (br_addr !== 4'h0) begin bad++; $display("FAIL rst_br_addr got=%h exp=0", br_addr); end
        fetch(32'd0, ins, cmd, ca, early);
        total++; if (cmd !== 1'b1) begin bad++; $display("FAIL t1_miss got=%b exp=1", cmd); end
        total++; if (ins !== 32'hB7C6A980) begin bad++; $display("FAIL t1_instr got=%h exp=b7c6a980", ins); end
        total++; if (data_ready !== 1'b1) begin bad++; $display("FAIL t1_ready got=%b exp=1", data_ready); end
        total++; if (early !== 1'b1) begin bad++; $display("FAIL t1_early_ready got=%b exp=1", early); end
`ifdef ICACHE_STATS_EN
        total++; if (dut.stat_cache_misses !== 32'd1) begin bad++; $display("FAIL t1_stat_miss got=%0d exp=1", dut.stat_cache_misses); end
`endif
    endtask

    task automatic test_hits();
        logic [31:0] addrs [3] = '{32'd4, 32'd8, 32'd16};
        logic [31:0] exps  [3] = '{32'h3F5A2E14, 32'hAB4C3E6F, 32'hD5B8A9C4};
        logic [31:0] ins; bit cmd, early; logic [3:0] ca;
        for (int i = 0; i < 3; i++) begin
            fetch(addrs[i], ins, cmd, ca, early);
            total++; if (cmd !== 1'b0) begin bad++; $display("FAIL t2_hit_no_cmd a=%h got=%b exp=0", addrs[i], cmd); end
            total++; if (ins !== exps[i]) begin bad++; $display("FAIL t2_instr a=%h got=%h exp=%h", addrs[i], ins, exps[i]); end
            total++; if (data_ready !== 1'b1) begin bad++; $display("FAIL t2_ready a=%h got=%b exp=1", addrs[i], data_ready); end
        end
`ifdef ICACHE_STATS_EN
        total++; if (dut.stat_cache_hits !== 32'd3) begin bad++; $display("FAIL t2_stat_hits got=%0d exp=3", dut.stat_cache_hits); end
`endif
    endtask

    task automatic test_second_way();
        logic [31:0] ins; bit cmd, early; logic [3:0] ca;
        fetch(32'd32, ins, cmd, ca, early);
        total++; if (cmd !== 1'b1 || ca !== 4'd4) begin bad++; $display("FAIL t3_miss32 got=%b/%h exp=1/4", cmd, ca); end
        total++; if (ins !== 32'h2F5E3C7A) begin bad++; $display("FAIL t3_instr32 got=%h exp=2f5e3c7a", ins); end
        fetch(32'd68, ins, cmd, ca, early);
        total++; if (cmd !== 1'b1 || ca !== 4'd8) begin bad++; $display("FAIL t3_miss68 got=%b/%h exp=1/8", cmd, ca); end
        total++; if (ins !== 32'h0A1B2C3D) begin bad++; $display("FAIL t3_instr68 got=%h exp=0a1b2c3d", ins); end
        fetch(32'd0, ins, cmd, ca, early);
        total++; if (cmd !== 1'b0) begin bad++; $display("FAIL t3_hit0 got=%b exp=0", cmd); end
        total++; if (ins !== 32'hB7C6A980) begin bad++; $display("FAIL t3_instr0 got=%h exp=b7c6a980", ins); end
`ifdef ICACHE_STATS_EN
        total++; if (dut.stat_cache_misses !== 32'd3) begin bad++; $display("FAIL t3_stat_miss got=%0d exp=3", dut.stat_cache_misses); end
`endif
    endtask

    task automatic test_eviction();
        logic [31:0] ins; bit cmd, early; logic [3:0] ca;
        fetch(32'd128, ins, cmd, ca, early);
        total++; if (cmd !== 1'b1 || ca !== 4'd0) begin bad++; $display("FAIL t4_miss128 got=%b/%h exp=1/0", cmd, ca); end
        total++; if (ins !== 32'hB7C6A980) begin bad++; $display("FAIL t4_instr128 got=%h exp=b7c6a980", ins); end
        fetch(32'd0, ins, cmd, ca, early);
        total++; if (cmd !== 1'b1) begin bad++; $display("FAIL t4_miss0 got=%b exp=1", cmd); end
        total++; if (ins !== 32'hB7C6A980) begin bad++; $display("FAIL t4_instr0 got=%h exp=b7c6a980", ins); end
        fetch(32'd68, ins, cmd, ca, early);
        total++; if (cmd !== 1'b1) begin bad++; $display("FAIL t4_miss68 got=%b exp=1", cmd); end
        total++; if (ins !== 32'h0A1B2C3D) begin bad++; $display("FAIL t4_instr68 got=%h exp=0a1b2c3d", ins); end
    endtask

    task automatic test_flush();
        logic [31:0] ins; bit cmd, early, seen; logic [3:0] ca;
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL t5_flush_busy got=%b exp=1", busy); end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL t5_flush_done got=%b exp=0", busy); end
`ifdef ICACHE_STATS_EN
        total++; if (dut.stat_flushes !== 32'd1) begin bad++; $display("FAIL t5_stat_flush got=%0d exp=1", dut.stat_flushes); end
`endif
        fetch(32'd4, ins, cmd, ca, early);
        total++; if (cmd !== 1'b1) begin bad++; $display("FAIL t5_miss4 got=%b exp=1", cmd); end
        total++; if (ins !== 32'h3F5A2E14) begin bad++; $display("FAIL t5_instr4 got=%h exp=3f5a2e14", ins); end

        // Flush raised mid-fill must wait for the fill, then invalidate it.
        @(negedge clk);
        enable = 1'b1; address = 32'd32;
        @(posedge clk);
        #1 enable = 1'b0;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (br_cmd_en) seen = 1;
        end
        total++; if (!seen) begin bad++; $display("FAIL t5_fill_cmd got=0 exp=1"); end
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (!busy) seen = 1;
        end
        total++; if (!seen) begin bad++; $display("FAIL t5_fill_done got=busy exp=idle"); end
        total++; if (instruction !== 32'h2F5E3C7A) begin bad++; $display("FAIL t5_instr32 got=%h exp=2f5e3c7a", instruction); end
        @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL t5_pending_flush got=%b exp=1", busy); end
        repeat (2) @(negedge clk);
`ifdef ICACHE_STATS_EN
        total++; if (dut.stat_flushes !== 32'd2) begin bad++; $display("FAIL t5_stat_flush2 got=%0d exp=2", dut.stat_flushes); end
`endif
        fetch(32'd32, ins, cmd, ca, early);
        total++; if (cmd !== 1'b1) begin bad++; $display("FAIL t5_refetch_miss got=%b exp=1", cmd); end
        total++; if (ins !== 32'h2F5E3C7A) begin bad++; $display("FAIL t5_refetch_instr got=%h exp=2f5e3c7a", ins); end
    endtask

    task automatic test_reset_mid_fill();
        logic [31:0] ins; bit cmd, early, seen; logic [3:0] ca;
        @(negedge clk);
        enable = 1'b1; address = 32'd0;
        @(posedge clk);
        #1 enable = 1'b0;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (br_cmd_en) seen = 1;
        end
        total++; if (!seen) begin bad++; $display("FAIL t6_cmd got=0 exp=1"); end
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++; if (data_ready !== 1'b0) begin bad++; $display("FAIL t6_ready got=%b exp=0", data_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL t6_busy got=%b exp=0", busy); end
        fetch(32'd0, ins, cmd, ca, early);
        total++; if (cmd !== 1'b1) begin bad++; $display("FAIL t6_miss0 got=%b exp=1", cmd); end
        total++; if (ins !== 32'hB7C6A980) begin bad++; $display("FAIL t6_instr0 got=%h exp=b7c6a980", ins); end
        fetch(32'd16, ins, cmd, ca, early);
        total++; if (cmd !== 1'b0) begin bad++; $display("FAIL t6_hit16 got=%b exp=0", cmd); end
        total++; if (ins !== 32'hD5B8A9C4) begin bad++; $display("FAIL t6_instr16 got=%h exp=d5b8a9c4", ins); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = {32'hC000_0000 + 32'(2 * i + 1), 32'hC000_0000 + 32'(2 * i)};
        ram[0]        = {32'h3F5A2E14, 32'hB7C6A980};
        ram[1][31:0]  = 32'hAB4C3E6F;
        ram[2][31:0]  = 32'hD5B8A9C4;
        ram[4][31:0]  = 32'h2F5E3C7A;
        ram[8][63:32] = 32'h0A1B2C3D;

        test_reset();
        test_hits();
        test_second_way();
        test_eviction();
        test_flush();
        test_reset_mid_fill();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
